// File: rtl/sprite_line_eval.sv
// Per-scanline sprite evaluator: scans OAM and builds a double-buffered
// list of sprites that intersect the requested line.
module sprite_line_eval #(
  parameter int MAX_PER_LINE = 32,
  parameter int OAM_DEPTH    = 64,
  parameter int OAM_AW       = $clog2(OAM_DEPTH)
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            line_start,
  input  logic [9:0]                      line_y,
  input  logic [1:0]                      h_mode,
  output logic [OAM_AW-1:0]               oam_addr,
  input  logic [31:0]                     oam_data,
  input  logic [$clog2(MAX_PER_LINE)-1:0] rd_idx,
  output logic [OAM_AW+5:0]               rd_entry,
  output logic [$clog2(MAX_PER_LINE):0]   front_count,
  output logic                            front_overflow,
  output logic                            front_complete,
  output logic                            done
);

  localparam int CW = $clog2(MAX_PER_LINE);
  localparam int EW = OAM_AW + 6;
  localparam logic [CW:0] CMAX = (CW+1)'(MAX_PER_LINE);
  localparam logic [OAM_AW-1:0] LAST = OAM_AW'(OAM_DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic [1:0][MAX_PER_LINE-1:0][EW-1:0] list_q;
  logic [1:0][CW:0] cnt_q;
  logic [1:0]       ovf_q;
  logic             cmp_q;
  logic             front_sel;
  logic             bk;
  logic [9:0]       y_q;
  logic [1:0]       h_q;
  logic             addr_live;
  logic             p1_vld;
  logic [OAM_AW-1:0] p1_idx;

  logic [4:0]  hmax;
  logic [10:0] diff;
  logic        hit;
  logic        eval;
  logic        full;
  logic [4:0]  row;
  logic        unused_bits;

  assign bk   = ~front_sel;
  assign eval = (state_q == SCAN) && p1_vld;
  assign full = (cnt_q[bk] == CMAX);

  always_comb begin
    hmax = 5'd15;
    unique case (1'b1)
      (h_q == 2'b00): hmax = 5'd7;
      (h_q == 2'b10): hmax = 5'd31;
      default:        hmax = 5'd15;
    endcase
  end

  // 11-bit difference keeps sprites near y=1023 from wrapping onto line 0
  assign diff = {1'b0, y_q} - {1'b0, oam_data[27:18]};
  assign hit  = oam_data[31] && !diff[10] && (diff <= {6'b0, hmax});
  assign row  = oam_data[30] ? (hmax - diff[4:0]) : diff[4:0];

  assign unused_bits = ^{oam_data[29:28], oam_data[17:0]};

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: state_d = IDLE;
      SCAN: begin
        if (eval && ((hit && full) || (p1_idx == LAST)))
          state_d = DONE;
      end
      DONE: state_d = DONE;
      default: state_d = IDLE;
    endcase
    if (line_start)
      state_d = SCAN;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      list_q    <= '0;
      cnt_q     <= '0;
      ovf_q     <= '0;
      cmp_q     <= 1'b0;
      front_sel <= 1'b0;
      y_q       <= '0;
      h_q       <= '0;
      oam_addr  <= '0;
      addr_live <= 1'b0;
      p1_vld    <= 1'b0;
      p1_idx    <= '0;
    end else if (line_start) begin
      front_sel         <= bk;
      list_q[front_sel] <= '0;
      cnt_q[front_sel]  <= '0;
      ovf_q[front_sel]  <= 1'b0;
      cmp_q             <= (state_q != SCAN);
      y_q               <= line_y;
      h_q               <= h_mode;
      oam_addr          <= '0;
      addr_live         <= 1'b1;
      p1_vld            <= 1'b0;
    end else if (state_q == SCAN) begin
      p1_vld <= addr_live;
      p1_idx <= oam_addr;
      if (oam_addr == LAST)
        addr_live <= 1'b0;
      else
        oam_addr <= oam_addr + 1'b1;
      if (eval && hit) begin
        if (full) begin
          ovf_q[bk] <= 1'b1;
        end else begin
          list_q[bk][cnt_q[bk][CW-1:0]] <= {p1_idx, row, 1'b1};
          cnt_q[bk] <= cnt_q[bk] + 1'b1;
        end
      end
    end
  end

  assign done           = (state_q == DONE);
  assign front_count    = cnt_q[front_sel];
  assign front_overflow = ovf_q[front_sel];
  assign front_complete = cmp_q;
  assign rd_entry = ({1'b0, rd_idx} < front_count) ?
                    list_q[front_sel][rd_idx] : '0;

endmodule

// File: tb/tb_sprite_line_eval.sv
// Randomized scoreboard bench for sprite_line_eval with a line-level
// reference model of the sprite list each scan should produce.
module tb_sprite_line_eval;
  localparam int MAXL  = 32;
  localparam int DEPTH = 64;
  localparam int AW    = 6;
  localparam int CW    = 5;
  localparam int EW    = AW + 6;

  logic          clk = 0;
  logic          reset_n = 0;
  logic          line_start = 0;
  logic [9:0]    line_y = 0;
  logic [1:0]    h_mode = 0;
  logic [AW-1:0] oam_addr;
  logic [31:0]   oam_data = 0;
  logic [CW-1:0] rd_idx = 0;
  logic [EW-1:0] rd_entry;
  logic [CW:0]   front_count;
  logic          front_overflow;
  logic          front_complete;
  logic          done;

  sprite_line_eval #(
    .MAX_PER_LINE(MAXL),
    .OAM_DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .line_start(line_start),
    .line_y(line_y),
    .h_mode(h_mode),
    .oam_addr(oam_addr),
    .oam_data(oam_data),
    .rd_idx(rd_idx),
    .rd_entry(rd_entry),
    .front_count(front_count),
    .front_overflow(front_overflow),
    .front_complete(front_complete),
    .done(done)
  );

  always #50 clk = ~clk;

  logic [31:0] oam [DEPTH];
  always @(posedge clk) oam_data <= oam[oam_addr];

  typedef struct packed {
    logic [CW:0]                 cnt;
    logic                        ovf;
    logic                        cmp;
    logic [MAXL-1:0][EW-1:0]     ent;
  } exp_t;

  exp_t q[$];
  exp_t back_exp;
  int   n_chk = 0;
  int   n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
    end
  endtask

  // Scan OAM indices [0, limit) the way the sprite rules describe it
  function automatic exp_t model(input logic [9:0] y, input logic [1:0] hm,
                                 input int limit, input bit cmp,
                                 output int dedge);
    exp_t e;
    int h, d, row;
    logic [31:0] w;
    e = '0;
    e.cmp = cmp;
    h = (hm == 2'd0) ? 8 : (hm == 2'd2) ? 32 : 16;
    dedge = DEPTH + 1;
    for (int i = 0; i < limit; i++) begin
      w = oam[i];
      d = int'(y) - int'(w[27:18]);
      if (w[31] && d >= 0 && d < h) begin
        if (int'(e.cnt) == MAXL) begin
          e.ovf = 1'b1;
          dedge = i + 2;
          break;
        end
        row = w[30] ? (h - 1 - d) : d;
        e.ent[e.cnt] = {AW'(i), 5'(row), 1'b1};
        e.cnt++;
      end
    end
    return e;
  endfunction

  // mode 0: run to done; 1: return after stop_k cycles for an abort;
  // 2: same, caller then pulses reset. Called at a negedge.
  task automatic run_line(input logic [9:0] y, input logic [1:0] h,
                          input int mode, input int stop_k);
    int   k, dedge;
    exp_t nx;
    line_start = 1;
    line_y = y;
    h_mode = h;
    q.push_back(back_exp);
    @(negedge clk);
    line_start = 0;
    k = 0;
    chk("addr_restart", 64'(oam_addr), 64'd0);
    if (mode == 0) begin
      nx = model(y, h, DEPTH, 1'b1, dedge);
      while (!done && k < 200) begin
        @(negedge clk);
        k++;
        line_y = 10'($urandom);
        h_mode = 2'($urandom);
      end
      chk("done_edge", 64'(k), 64'(dedge));
    end else begin
      nx = model(y, h, stop_k - 1, 1'b0, dedge);
      repeat (stop_k) begin
        @(negedge clk);
        line_y = 10'($urandom);
        h_mode = 2'($urandom);
      end
      chk("done_mid_scan", 64'(done), 64'd0);
    end
    back_exp = nx;
  endtask

  task automatic fill_oam(input logic [9:0] y, input bit dense);
    int r;
    for (int i = 0; i < DEPTH; i++) begin
      r = dense ? $urandom_range(0, 20) : $urandom_range(0, 45);
      oam[i] = {dense ? 1'b1 : 1'($urandom), 3'($urandom),
                10'(int'(y) - r), 18'($urandom)};
    end
  endtask

  task automatic clear_oam();
    for (int i = 0; i < DEPTH; i++) oam[i] = '0;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_addr"}, 64'(oam_addr), 64'd0);
    chk({tag, "_count"}, 64'(front_count), 64'd0);
    chk({tag, "_ovf"}, 64'(front_overflow), 64'd0);
    chk({tag, "_cmp"}, 64'(front_complete), 64'd0);
    chk({tag, "_entry"}, 64'(rd_entry), 64'd0);
  endtask

  // Monitor: every accepted line_start exposes a new front list
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      if (reset_n && line_start) begin
        @(negedge clk);
        if (q.size() == 0) begin
          chk("sb_underflow", 64'd1, 64'd0);
        end else begin
          e = q.pop_front();
          chk("front_count", 64'(front_count), 64'(e.cnt));
          chk("front_overflow", 64'(front_overflow), 64'(e.ovf));
          chk("front_complete", 64'(front_complete), 64'(e.cmp));
          for (int i = 0; i < MAXL; i++) begin
            rd_idx = CW'(i);
            #1;
            chk($sformatf("entry%0d", i), 64'(rd_entry), 64'(e.ent[i]));
          end
        end
      end
    end
  end

  initial begin
    #(100 * 20000);
    $display("FAIL watchdog: simulation did not end in time");
    $fatal(1);
  end

  initial begin
    logic [9:0] y;
    clear_oam();
    back_exp = '0;
    back_exp.cmp = 1'b1;
    repeat (2) @(negedge clk);
    check_zero("reset");
    reset_n = 1;
    @(negedge clk);
    repeat (4) @(negedge clk);
    chk("idle_done", 64'(done), 64'd0);
    chk("idle_addr", 64'(oam_addr), 64'd0);

    oam[3] = {1'b1, 3'b000, 10'd100, 10'd40, 8'h11};
    oam[9] = {1'b1, 3'b100, 10'd92, 10'd7, 8'h22};
    run_line(10'd105, 2'b01, 0, 0);

    for (int i = 0; i < DEPTH; i++)
      oam[i] = {1'b1, 3'($urandom), 10'd0, 18'($urandom)};
    run_line(10'd0, 2'($urandom), 0, 0);

    clear_oam();
    oam[5] = {1'b1, 3'b000, 10'd200, 18'd0};
    run_line(10'd215, 2'b01, 0, 0);
    run_line(10'd215, 2'b10, 0, 0);
    run_line(10'd215, 2'b00, 0, 0);
    oam[5] = {1'b1, 3'b000, 10'd1020, 18'd0};
    run_line(10'd2, 2'b10, 0, 0);

    y = 10'($urandom);
    fill_oam(y, 1'b0);
    run_line(y, 2'($urandom), 1, 9);
    y = 10'($urandom);
    fill_oam(y, 1'b0);
    run_line(y, 2'($urandom), 0, 0);
    run_line(y, 2'($urandom), 1, $urandom_range(2, 60));
    run_line(y, 2'($urandom), 0, 0);

    run_line(y, 2'($urandom), 2, 20);
    reset_n = 0;
    #1;
    check_zero("mid_reset");
    @(negedge clk);
    reset_n = 1;
    back_exp = '0;
    back_exp.cmp = 1'b1;
    repeat (10) @(negedge clk);
    chk("post_reset_done", 64'(done), 64'd0);
    run_line(y, 2'($urandom), 0, 0);

    for (int n = 0; n < 8; n++) begin
      y = 10'($urandom);
      if (n == 3) y = 10'd5;
      fill_oam(y, n % 3 == 0);
      run_line(y, 2'($urandom), 0, 0);
    end
    run_line(10'd0, 2'd0, 1, 3);
    repeat (3) @(negedge clk);
    chk("sb_drained", 64'(q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
